// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_ctrl
// Brief    : PC sequencer for a combinational instruction ROM with a 2-entry
//            fetch buffer, valid/ready drain to decode and flushing redirects.
// Revision : 1.0 - initial release
// ============================================================================
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h00400000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] Address,
  input  logic [31:0] Instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic [31:0] fetched_count,
  output logic        fault_misaligned
);

  localparam logic [1:0] c_full = 2'(BUF_DEPTH);

  logic [31:0] r_fetch_pc;
  logic [1:0]  r_count;
  logic [31:0] r_head_instr;
  logic [31:0] r_head_pc;
  logic [31:0] r_head_pc4;
  logic [31:0] r_tail_instr;
  logic [31:0] r_tail_pc;
  logic [31:0] r_fetched;
  logic        r_fault;

  logic w_deq;
  logic w_enq;
  logic w_load_head_new;
  logic w_load_head_tail;
  logic w_load_tail;

  assign w_deq = (r_count != 2'd0) && out_ready;
  assign w_enq = !redirect_valid && ((r_count != c_full) || w_deq);

  // Entry 0 is always the head; entry 1 only holds data when count is 2.
  assign w_load_head_new  = w_enq && ((r_count == 2'd0) || ((r_count == 2'd1) && w_deq));
  assign w_load_head_tail = w_deq && (r_count == 2'd2);
  assign w_load_tail      = w_enq && (((r_count == 2'd1) && !w_deq) || (r_count == 2'd2));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc   <= RESET_PC;
      r_count      <= 2'd0;
      r_head_instr <= 32'd0;
      r_head_pc    <= 32'd0;
      r_head_pc4   <= 32'd4;
      r_tail_instr <= 32'd0;
      r_tail_pc    <= 32'd0;
      r_fetched    <= 32'd0;
      r_fault      <= 1'b0;
    end else begin
      // A handshake coinciding with a redirect still counts as delivered.
      if (w_deq) begin
        r_fetched <= r_fetched + 32'd1;
      end
      if (redirect_valid) begin
        r_count    <= 2'd0;
        r_fetch_pc <= {redirect_pc[31:2], 2'b00};
        if (redirect_pc[1:0] != 2'b00) begin
          r_fault <= 1'b1;
        end
      end else begin
        if (w_enq) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_load_head_new) begin
          r_head_instr <= Instruction;
          r_head_pc    <= r_fetch_pc;
          r_head_pc4   <= r_fetch_pc + 32'd4;
        end else if (w_load_head_tail) begin
          r_head_instr <= r_tail_instr;
          r_head_pc    <= r_tail_pc;
          r_head_pc4   <= r_tail_pc + 32'd4;
        end
        if (w_load_tail) begin
          r_tail_instr <= Instruction;
          r_tail_pc    <= r_fetch_pc;
        end
        if (w_enq && !w_deq) begin
          r_count <= r_count + 2'd1;
        end else if (!w_enq && w_deq) begin
          r_count <= r_count - 2'd1;
        end
      end
    end
  end

  assign Address          = r_fetch_pc;
  assign out_valid        = (r_count != 2'd0);
  assign out_instr        = r_head_instr;
  assign out_pc           = r_head_pc;
  assign out_pc_plus4     = r_head_pc4;
  assign fetched_count    = r_fetched;
  assign fault_misaligned = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_fetch_ctrl
// Brief    : Directed self-checking bench for imem_fetch_ctrl with a ROM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] Instruction;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic [31:0] fetched_count;
  logic        fault_misaligned;

  int errors;
  int checks;

  imem_fetch_ctrl #(
    .RESET_PC (32'h00400000),
    .BUF_DEPTH(2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .Address         (Address),
    .Instruction     (Instruction),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .out_pc_plus4    (out_pc_plus4),
    .fetched_count   (fetched_count),
    .fault_misaligned(fault_misaligned)
  );

  // ROM: word k holds 0x10000000 + k.
  assign Instruction = 32'h10000000 + {24'd0, Address[9:2]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    #12;
    checks++; if (Address !== 32'h00400000) begin errors++; $display("FAIL reset_addr actual=%h required=%h", Address, 32'h00400000); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid actual=%b required=0", out_valid); end
    checks++; if (out_pc_plus4 !== 32'd4) begin errors++; $display("FAIL reset_pc4 actual=%h required=%h", out_pc_plus4, 32'd4); end
    checks++; if (fetched_count !== 32'd0) begin errors++; $display("FAIL reset_count actual=%h required=0", fetched_count); end
    checks++; if (fault_misaligned !== 1'b0) begin errors++; $display("FAIL reset_fault actual=%b required=0", fault_misaligned); end
    step();
    reset = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_valid actual=%b required=1", out_valid); end
    checks++; if (out_pc !== 32'h00400000) begin errors++; $display("FAIL first_pc actual=%h required=%h", out_pc, 32'h00400000); end
    checks++; if (out_instr !== 32'h10000000) begin errors++; $display("FAIL first_instr actual=%h required=%h", out_instr, 32'h10000000); end
    checks++; if (out_pc_plus4 !== 32'h00400004) begin errors++; $display("FAIL first_pc4 actual=%h required=%h", out_pc_plus4, 32'h00400004); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (Address !== 32'h00400008) begin errors++; $display("FAIL stall_addr[%0d] actual=%h required=%h", i, Address, 32'h00400008); end
      checks++; if (out_pc !== 32'h00400000) begin errors++; $display("FAIL stall_pc[%0d] actual=%h required=%h", i, out_pc, 32'h00400000); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] actual=%b required=1", i, out_valid); end
    end
    checks++; if (fetched_count !== 32'd0) begin errors++; $display("FAIL stall_count actual=%h required=0", fetched_count); end
  endtask

  task automatic test_drain();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_pc !== 32'h00400000 + 32'(4 * i)) begin errors++; $display("FAIL drain_pc[%0d] actual=%h required=%h", i, out_pc, 32'h00400000 + 32'(4 * i)); end
      checks++; if (out_instr !== 32'h10000000 + 32'(i)) begin errors++; $display("FAIL drain_instr[%0d] actual=%h required=%h", i, out_instr, 32'h10000000 + 32'(i)); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d] actual=%b required=1", i, out_valid); end
      step();
    end
    checks++; if (fetched_count !== 32'd4) begin errors++; $display("FAIL drain_count actual=%h required=4", fetched_count); end
    checks++; if (out_pc !== 32'h00400010) begin errors++; $display("FAIL drain_next_pc actual=%h required=%h", out_pc, 32'h00400010); end
    checks++; if (Address !== 32'h00400018) begin errors++; $display("FAIL drain_addr actual=%h required=%h", Address, 32'h00400018); end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1; redirect_pc = 32'h00400030;
    step();
    redirect_valid = 1'b0;
    checks++; if (fetched_count !== 32'd5) begin errors++; $display("FAIL redir_count actual=%h required=5", fetched_count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_bubble actual=%b required=0", out_valid); end
    checks++; if (Address !== 32'h00400030) begin errors++; $display("FAIL redir_addr actual=%h required=%h", Address, 32'h00400030); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL redir_valid actual=%b required=1", out_valid); end
    checks++; if (out_pc !== 32'h00400030) begin errors++; $display("FAIL redir_pc actual=%h required=%h", out_pc, 32'h00400030); end
    checks++; if (out_instr !== 32'h1000000C) begin errors++; $display("FAIL redir_instr actual=%h required=%h", out_instr, 32'h1000000C); end
    checks++; if (fetched_count !== 32'd5) begin errors++; $display("FAIL redir_empty_count actual=%h required=5", fetched_count); end
  endtask

  task automatic test_misaligned();
    out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h00400032;
    step();
    redirect_valid = 1'b0;
    checks++; if (Address !== 32'h00400030) begin errors++; $display("FAIL mis_addr actual=%h required=%h", Address, 32'h00400030); end
    checks++; if (fault_misaligned !== 1'b1) begin errors++; $display("FAIL mis_fault actual=%b required=1", fault_misaligned); end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (fault_misaligned !== 1'b1) begin errors++; $display("FAIL mis_sticky[%0d] actual=%b required=1", i, fault_misaligned); end
    end
    redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFC;
    step();
    redirect_valid = 1'b0;
    checks++; if (fault_misaligned !== 1'b1) begin errors++; $display("FAIL mis_after_redir actual=%b required=1", fault_misaligned); end
    step();
    checks++; if (out_pc !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_pc actual=%h required=%h", out_pc, 32'hFFFFFFFC); end
    checks++; if (out_pc_plus4 !== 32'd0) begin errors++; $display("FAIL wrap_pc4 actual=%h required=0", out_pc_plus4); end
    checks++; if (out_instr !== 32'h100000FF) begin errors++; $display("FAIL wrap_instr actual=%h required=%h", out_instr, 32'h100000FF); end
    checks++; if (Address !== 32'd0) begin errors++; $display("FAIL wrap_addr actual=%h required=0", Address); end
  endtask

  task automatic test_back_to_back();
    redirect_valid = 1'b1; redirect_pc = 32'h00400100;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_first_valid actual=%b required=0", out_valid); end
    redirect_pc = 32'h00400200;
    step();
    redirect_valid = 1'b0;
    checks++; if (Address !== 32'h00400200) begin errors++; $display("FAIL b2b_addr actual=%h required=%h", Address, 32'h00400200); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid actual=%b required=0", out_valid); end
    step();
    checks++; if (out_pc !== 32'h00400200) begin errors++; $display("FAIL b2b_pc actual=%h required=%h", out_pc, 32'h00400200); end
    checks++; if (out_instr !== 32'h10000080) begin errors++; $display("FAIL b2b_instr actual=%h required=%h", out_instr, 32'h10000080); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_rst_valid actual=%b required=1", out_valid); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid actual=%b required=0", out_valid); end
    checks++; if (fetched_count !== 32'd0) begin errors++; $display("FAIL arst_count actual=%h required=0", fetched_count); end
    checks++; if (fault_misaligned !== 1'b0) begin errors++; $display("FAIL arst_fault actual=%b required=0", fault_misaligned); end
    checks++; if (Address !== 32'h00400000) begin errors++; $display("FAIL arst_addr actual=%h required=%h", Address, 32'h00400000); end
    #1;
    reset = 1'b1;
    step();
    checks++; if (out_pc !== 32'h00400000) begin errors++; $display("FAIL arst_first_pc actual=%h required=%h", out_pc, 32'h00400000); end
    checks++; if (out_instr !== 32'h10000000) begin errors++; $display("FAIL arst_first_instr actual=%h required=%h", out_instr, 32'h10000000); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_stall();
    test_drain();
    test_redirect();
    test_misaligned();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
